// File: rtl/freq_meter.sv
// Frequency meter: counts rising edges of an asynchronous square wave over a
// fixed gate window of GATE_CYCLES clk cycles and reports the count as freq.
// Consecutive windows run back to back while en stays high.
module freq_meter #(
    parameter int unsigned GATE_CYCLES = 100_000_000,
    parameter int unsigned CNT_W       = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq,
    output logic             valid,
    output logic             ovf,
    output logic             busy
);

    localparam int unsigned      TMR_W    = $clog2(GATE_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_GATE
    } state_t;

    state_t           r_state;
    logic             r_arm;
    logic [TMR_W-1:0] r_timer;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sat;
    logic [CNT_W-1:0] r_freq;
    logic             r_ovf;
    logic             r_valid;
    logic             r_busy;

    logic             r_s1;
    logic             r_s2;
    logic             r_s3;

    logic             w_edge;
    logic             w_cnt_full;
    logic             w_last;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_sat_next;

    // Two-flop synchronizer plus history flop for rising-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= sig_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Edge pulse and saturating next-count; sat marks an edge lost at full scale
    always_comb begin
        w_edge     = r_s2 & ~r_s3;
        w_cnt_full = (r_cnt == CNT_MAX);
        w_last     = (r_timer == TMR_LAST);
        w_cnt_next = r_cnt;
        if (w_edge && !w_cnt_full) begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end
        w_sat_next = r_sat | (w_edge & w_cnt_full);
    end

    // Control FSM: arm, gate, latch result; the closing cycle's edge is folded
    // into the latched value so a restarted window begins from a clean zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_arm   <= 1'b0;
            r_timer <= '0;
            r_cnt   <= '0;
            r_sat   <= 1'b0;
            r_freq  <= '0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_timer <= '0;
                    r_cnt   <= '0;
                    r_sat   <= 1'b0;
                    r_arm   <= 1'b0;
                    if (en) begin
                        r_state <= S_ARM;
                        r_busy  <= 1'b1;
                    end
                end
                S_ARM: begin
                    r_timer <= '0;
                    r_cnt   <= '0;
                    r_sat   <= 1'b0;
                    if (!en) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_arm   <= 1'b0;
                    end else if (r_arm) begin
                        r_state <= S_GATE;
                        r_arm   <= 1'b0;
                    end else begin
                        r_arm <= 1'b1;
                    end
                end
                S_GATE: begin
                    if (w_last) begin
                        r_freq  <= w_cnt_next;
                        r_ovf   <= w_sat_next;
                        r_valid <= 1'b1;
                        r_timer <= '0;
                        r_cnt   <= '0;
                        r_sat   <= 1'b0;
                        if (!en) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else if (!en) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_timer <= '0;
                        r_cnt   <= '0;
                        r_sat   <= 1'b0;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                        r_cnt   <= w_cnt_next;
                        r_sat   <= w_sat_next;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign freq  = r_freq;
    assign valid = r_valid;
    assign ovf   = r_ovf;
    assign busy  = r_busy;

endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 Parameter GATE_CYCLES, default 100_000_000, gate window length in clk cycles (1 s at 100 MHz).
REQ-002 Parameter CNT_W, default 20, width of the edge counter and the result.
REQ-003 clk  input  1  built-in 100 MHz clock; the only clock in the block.
REQ-004 rst  input  1  reset, synchronous to clk, active-high.
REQ-005 en  input  1  measurement enable; level-sensitive.
REQ-006 sig_in  input  1  external square wave to be measured; asynchronous to clk.
REQ-007 freq  output  CNT_W  rising-edge count of the last completed window; registered.
REQ-008 valid  output  1  one-cycle pulse when freq and ovf are updated.
REQ-009 ovf  output  1  the last completed window saturated; registered.
REQ-010 busy  output  1  high in ARM and GATE states.

Function
REQ-011 sig_in SHALL pass through a 2-flop synchronizer (s1, s2) followed by a history flop s3; edge = s2 & ~s3.
REQ-012 Latency from a sig_in rising edge to the edge pulse SHALL be 3 clk cycles.
REQ-013 The FSM SHALL have states IDLE, ARM and GATE.
REQ-014 IDLE -> ARM when en=1; the ARM state SHALL last exactly 2 cycles, flushing the synchronizer, with the edge counter held at 0.
REQ-015 ARM -> GATE after 2 cycles; the gate timer and edge counter SHALL both be 0 on GATE entry.
REQ-016 In GATE, the timer SHALL increment every cycle from 0 to GATE_CYCLES-1.
REQ-017 In GATE, the edge counter SHALL increment on each edge pulse.
REQ-018 The edge counter SHALL saturate at 2^CNT_W-1; when it does, an internal sat flag SHALL be set for the window.
REQ-019 On the GATE cycle where timer = GATE_CYCLES-1, the block SHALL set freq <= edge counter + edge (saturating), ovf <= sat, and valid <= 1 on the next cycle.
REQ-020 An edge on the final window cycle SHALL be counted in the window that is closing, never in the next one.
REQ-021 If en=1 at window end, the block SHALL restart GATE on the very next cycle with the timer, counter and sat flag cleared.
REQ-022 Back-to-back windows SHALL therefore be contiguous, with no dead cycles and no double-counted edge.
REQ-023 If en=0 at window end, the block SHALL go to IDLE after latching the result.
REQ-024 If en is deasserted mid-GATE, the block SHALL go to IDLE next cycle, discard the partial window, leave freq and ovf unchanged, and emit no valid pulse.
REQ-025 freq and ovf SHALL hold their values between valid pulses and while in IDLE.
REQ-026 valid SHALL never be high for two consecutive cycles unless GATE_CYCLES = 1; GATE_CYCLES SHALL be >= 2 (a configuration outside this range is illegal).
REQ-027 The gate timer width SHALL be clog2(GATE_CYCLES).
REQ-028 Arithmetic SHALL be unsigned with no wrap-around anywhere.

Reset
REQ-029 While rst=1, the FSM SHALL be in IDLE.
REQ-030 While rst=1, the outputs SHALL be freq=0, valid=0, ovf=0 and busy=0.
REQ-031 While rst=1, the values s1, s2, s3, the timer, the counter and sat SHALL all be 0.
REQ-032 rst SHALL take priority over en and over window completion, including on the final GATE cycle (no valid pulse is produced).
REQ-033 After rst is released with en=1, ARM SHALL begin on the first cycle after release.

Verification (GATE_CYCLES=1000, CNT_W=8 unless stated)
REQ-034 Stimulus: sig_in period 10 clk, en held high. Required response: valid every 1000 cycles with freq=100 (±1 on the first window only), ovf=0, and valid spacing exactly 1000.
REQ-035 Stimulus: sig_in period 3 clk (333 edges). Required response: freq=255, ovf=1; then switch to period 20 and the next full window gives freq=50, ovf=0.
REQ-036 Stimulus: a single sig_in rising edge timed so its edge pulse lands on timer=999. Required response: it is counted in the closing window (freq=1), and the next window gives freq=0.
REQ-037 Stimulus: en dropped at timer=500. Required response: no valid pulse, freq holds its previous value, busy=0 next cycle; en re-raised gives ARM for 2 cycles, then GATE.
REQ-038 Stimulus: rst asserted on timer=999. Required response: no valid pulse; freq=0, ovf=0 and busy=0 on the following cycle.
REQ-039 Stimulus: GATE_CYCLES=100_000_000, CNT_W=20, sig_in period 212,992 clk (469.5 Hz). Required response: freq alternates between 469 and 470, ovf=0.
